tlp_rx_demux: RTL and testbench

Receive-side counterpart of the TLP TX multiplexer: takes the single PCIe core RX AXI-Stream and steers each TLP, whole and in order, to one of two sinks. Completions (Cpl/CplD, and the locked variants CplLk/CplDLk) go to sink 2, the completion/DMA-read return path. All other TLPs go to sink 1, the request path toward the Ethernet encapsulator. Each output is a registered stage, and a per-sink TLP counter is provided for debug.

---
 rtl/tlp_rx_demux_if.sv | 21 ++
 rtl/tlp_rx_demux.sv | 144 ++++++++++++++
 tb/tb_tlp_rx_demux.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlp_rx_demux_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlp_rx_demux_if : AXI-Stream bundle for the PCIe RX path and its two sinks
// Revision: 1.0
// ---------------------------------------------------------------------------
interface tlp_rx_demux_if #(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
   parameter int USER_WIDTH   = 22
);
   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [KEEP_WIDTH-1:0]   tkeep;
   logic [C_DATA_WIDTH-1:0] tdata;
   logic [USER_WIDTH-1:0]   tuser;

   modport master (output tvalid, tlast, tkeep, tdata, tuser, input tready);
   modport slave  (input tvalid, tlast, tkeep, tdata, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/tlp_rx_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tlp_rx_demux : steers whole RX TLPs to sink 1 (requests) or sink 2 (completions)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tlp_rx_demux #(
   parameter int C_DATA_WIDTH = 64,
   parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
   input  wire logic         pcie_clk,
   input  wire logic         pcie_rst,
   tlp_rx_demux_if.slave     pcie_rx,
   tlp_rx_demux_if.master    pcie_rx1,
   tlp_rx_demux_if.master    pcie_rx2,
   output logic [31:0]       rx1_tlp_count,
   output logic [31:0]       rx2_tlp_count
);

   localparam int USER_WIDTH = 22;

   typedef enum logic [1:0] {
      ST_SOP   = 2'd0,
      ST_BODY1 = 2'd1,
      ST_BODY2 = 2'd2
   } state_t;

   state_t                  state_q, state_d;

   logic                    rx1_tvalid_q, rx1_tvalid_d;
   logic                    rx1_tlast_q,  rx1_tlast_d;
   logic [KEEP_WIDTH-1:0]   rx1_tkeep_q,  rx1_tkeep_d;
   logic [C_DATA_WIDTH-1:0] rx1_tdata_q,  rx1_tdata_d;
   logic [USER_WIDTH-1:0]   rx1_tuser_q,  rx1_tuser_d;

   logic                    rx2_tvalid_q, rx2_tvalid_d;
   logic                    rx2_tlast_q,  rx2_tlast_d;
   logic [KEEP_WIDTH-1:0]   rx2_tkeep_q,  rx2_tkeep_d;
   logic [C_DATA_WIDTH-1:0] rx2_tdata_q,  rx2_tdata_d;
   logic [USER_WIDTH-1:0]   rx2_tuser_q,  rx2_tuser_d;

   logic [31:0]             rx1_tlp_count_q, rx1_tlp_count_d;
   logic [31:0]             rx2_tlp_count_q, rx2_tlp_count_d;

   logic dest_is_cpl, is_sop, free1, free2, sel2, rx_ready, accept, load1, load2;

   always_comb begin
      // Type 01010 / 01011 (Cpl, CplD, CplLk, CplDLk) regardless of Fmt
      dest_is_cpl = (pcie_rx.tdata[28:25] == 4'b0101);
      free1       = ~rx1_tvalid_q | pcie_rx1.tready;
      free2       = ~rx2_tvalid_q | pcie_rx2.tready;

      is_sop   = 1'b0;
      sel2     = 1'b0;
      rx_ready = 1'b0;
      case (state_q)
         ST_BODY1: rx_ready = free1;
         ST_BODY2: begin
            sel2     = 1'b1;
            rx_ready = free2;
         end
         default: begin
            is_sop   = 1'b1;
            sel2     = dest_is_cpl;
            rx_ready = dest_is_cpl ? free2 : free1;
         end
      endcase

      accept = pcie_rx.tvalid & rx_ready;
      load1  = accept & ~sel2;
      load2  = accept &  sel2;

      state_d = state_q;
      if (accept) begin
         if (pcie_rx.tlast) begin
            state_d = ST_SOP;
         end else if (is_sop) begin
            state_d = dest_is_cpl ? ST_BODY2 : ST_BODY1;
         end
      end

      rx1_tvalid_d = load1 ? 1'b1 : (pcie_rx1.tready ? 1'b0 : rx1_tvalid_q);
      rx1_tlast_d  = load1 ? pcie_rx.tlast : rx1_tlast_q;
      rx1_tkeep_d  = load1 ? pcie_rx.tkeep : rx1_tkeep_q;
      rx1_tdata_d  = load1 ? pcie_rx.tdata : rx1_tdata_q;
      rx1_tuser_d  = load1 ? pcie_rx.tuser : rx1_tuser_q;

      rx2_tvalid_d = load2 ? 1'b1 : (pcie_rx2.tready ? 1'b0 : rx2_tvalid_q);
      rx2_tlast_d  = load2 ? pcie_rx.tlast : rx2_tlast_q;
      rx2_tkeep_d  = load2 ? pcie_rx.tkeep : rx2_tkeep_q;
      rx2_tdata_d  = load2 ? pcie_rx.tdata : rx2_tdata_q;
      rx2_tuser_d  = load2 ? pcie_rx.tuser : rx2_tuser_q;

      // A TLP counts once its final beat leaves the output register
      rx1_tlp_count_d = rx1_tlp_count_q + 32'(rx1_tvalid_q & pcie_rx1.tready & rx1_tlast_q);
      rx2_tlp_count_d = rx2_tlp_count_q + 32'(rx2_tvalid_q & pcie_rx2.tready & rx2_tlast_q);
   end

   always_ff @(posedge pcie_clk) begin
      if (pcie_rst) begin
         state_q         <= ST_SOP;
         rx1_tvalid_q    <= 1'b0;
         rx2_tvalid_q    <= 1'b0;
         rx1_tlp_count_q <= 32'd0;
         rx2_tlp_count_q <= 32'd0;
      end else begin
         state_q         <= state_d;
         rx1_tvalid_q    <= rx1_tvalid_d;
         rx2_tvalid_q    <= rx2_tvalid_d;
         rx1_tlp_count_q <= rx1_tlp_count_d;
         rx2_tlp_count_q <= rx2_tlp_count_d;
      end
   end

   // Payload registers need no reset: they are only observed behind tvalid
   always_ff @(posedge pcie_clk) begin
      rx1_tlast_q <= rx1_tlast_d;
      rx1_tkeep_q <= rx1_tkeep_d;
      rx1_tdata_q <= rx1_tdata_d;
      rx1_tuser_q <= rx1_tuser_d;
      rx2_tlast_q <= rx2_tlast_d;
      rx2_tkeep_q <= rx2_tkeep_d;
      rx2_tdata_q <= rx2_tdata_d;
      rx2_tuser_q <= rx2_tuser_d;
   end

   assign pcie_rx.tready  = rx_ready;

   assign pcie_rx1.tvalid = rx1_tvalid_q;
   assign pcie_rx1.tlast  = rx1_tlast_q;
   assign pcie_rx1.tkeep  = rx1_tkeep_q;
   assign pcie_rx1.tdata  = rx1_tdata_q;
   assign pcie_rx1.tuser  = rx1_tuser_q;

   assign pcie_rx2.tvalid = rx2_tvalid_q;
   assign pcie_rx2.tlast  = rx2_tlast_q;
   assign pcie_rx2.tkeep  = rx2_tkeep_q;
   assign pcie_rx2.tdata  = rx2_tdata_q;
   assign pcie_rx2.tuser  = rx2_tuser_q;

   assign rx1_tlp_count   = rx1_tlp_count_q;
   assign rx2_tlp_count   = rx2_tlp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tlp_rx_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tlp_rx_demux : directed + randomized bench with a TLP-level routing model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tlp_rx_demux;
   localparam int DW = 64;

   logic pcie_clk = 1'b0;
   logic pcie_rst = 1'b1;
   always #5 pcie_clk = ~pcie_clk;

   tlp_rx_demux_if #(.C_DATA_WIDTH(DW)) rx_if ();
   tlp_rx_demux_if #(.C_DATA_WIDTH(DW)) rx1_if ();
   tlp_rx_demux_if #(.C_DATA_WIDTH(DW)) rx2_if ();
   logic [31:0] rx1_cnt, rx2_cnt;

   tlp_rx_demux #(.C_DATA_WIDTH(DW)) dut (
      .pcie_clk      (pcie_clk),
      .pcie_rst      (pcie_rst),
      .pcie_rx       (rx_if),
      .pcie_rx1      (rx1_if),
      .pcie_rx2      (rx2_if),
      .rx1_tlp_count (rx1_cnt),
      .rx2_tlp_count (rx2_cnt)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic [21:0] u;
   } beat_t;

   beat_t       q1[$];
   beat_t       q2[$];
   beat_t       snap[1:2];
   bit          snap_v[1:2];
   int          vectors = 0;
   int          fails   = 0;
   int          lat_pending = 0;
   logic [31:0] n1, n2;
   bit          expect_full = 1'b0;
   bit          rand_ready  = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Completion types: 01010 (Cpl/CplD) and 01011 (CplLk/CplDLk)
   function automatic bit is_cpl(input logic [4:0] t);
      return (t == 5'b01010) || (t == 5'b01011);
   endfunction

   task automatic mon(input int n, input logic v, input logic r, input beat_t cur);
      beat_t e;
      if (snap_v[n]) begin
         check($sformatf("hold%0d_valid", n), 64'(v), 64'd1);
         check($sformatf("hold%0d_data", n), cur.d, snap[n].d);
         check($sformatf("hold%0d_klu", n), 64'({cur.k, cur.l, cur.u}),
               64'({snap[n].k, snap[n].l, snap[n].u}));
         snap_v[n] = 1'b0;
      end
      if (v && r) begin
         if ((n == 1 && q1.size() == 0) || (n == 2 && q2.size() == 0)) begin
            check($sformatf("spurious_beat_sink%0d", n), 64'(v), 64'd0);
         end else begin
            if (n == 1) e = q1.pop_front();
            else        e = q2.pop_front();
            check($sformatf("sink%0d_data", n), cur.d, e.d);
            check($sformatf("sink%0d_keep_last_user", n), 64'({cur.k, cur.l, cur.u}),
                  64'({e.k, e.l, e.u}));
         end
      end else if (v) begin
         snap[n]   = cur;
         snap_v[n] = 1'b1;
      end
   endtask

   always @(negedge pcie_clk) begin
      beat_t c1, c2;
      if (pcie_rst) begin
         snap_v[1]   = 1'b0;
         snap_v[2]   = 1'b0;
         lat_pending = 0;
      end else begin
         if (lat_pending == 1)      check("latency_sink1", 64'(rx1_if.tvalid), 64'd1);
         else if (lat_pending == 2) check("latency_sink2", 64'(rx2_if.tvalid), 64'd1);
         lat_pending = 0;
         c1 = '{d: rx1_if.tdata, k: rx1_if.tkeep, l: rx1_if.tlast, u: rx1_if.tuser};
         c2 = '{d: rx2_if.tdata, k: rx2_if.tkeep, l: rx2_if.tlast, u: rx2_if.tuser};
         mon(1, rx1_if.tvalid, rx1_if.tready, c1);
         mon(2, rx2_if.tvalid, rx2_if.tready, c2);
      end
   end

   always @(posedge pcie_clk) begin
      #1;
      if (rand_ready) begin
         rx1_if.tready = ($urandom % 4) != 0;
         rx2_if.tready = ($urandom % 4) != 0;
      end
   end

   task automatic send_beat(input bit to2, input beat_t b);
      bit acc = 1'b0;
      rx_if.tvalid = 1'b1;
      rx_if.tdata  = b.d;
      rx_if.tkeep  = b.k;
      rx_if.tlast  = b.l;
      rx_if.tuser  = b.u;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge pcie_clk);
         acc = rx_if.tready;
         if (expect_full) check("full_rate_tready", 64'(rx_if.tready), 64'd1);
         if (acc) begin
            if (to2) q2.push_back(b);
            else     q1.push_back(b);
         end
         @(posedge pcie_clk);
         #1;
      end
      if (acc) lat_pending = to2 ? 2 : 1;
      else     check("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic send_tlp(input logic [7:0] hdr, input int nbeats, input int maxgap);
      bit    to2 = is_cpl(hdr[4:0]);
      beat_t b;
      int    gap;
      if (to2) n2 = n2 + 32'd1;
      else     n1 = n1 + 32'd1;
      for (int i = 0; i < nbeats; i++) begin
         gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         if (gap > 0) begin
            rx_if.tvalid = 1'b0;
            rx_if.tdata  = {$urandom, $urandom};
            repeat (gap) begin
               @(posedge pcie_clk);
               #1;
            end
         end
         b.d = {$urandom, $urandom};
         if (i == 0) b.d[31:24] = hdr;
         b.k = 8'($urandom);
         b.l = (i == nbeats - 1);
         b.u = 22'($urandom);
         send_beat(to2, b);
      end
      rx_if.tvalid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 2000 && (q1.size() != 0 || q2.size() != 0); t++) @(posedge pcie_clk);
      if (q1.size() != 0 || q2.size() != 0)
         check("drain_timeout", 64'(q1.size() + q2.size()), 64'd0);
      @(posedge pcie_clk);
      #1;
   endtask

   task automatic check_counts(input string tag);
      @(negedge pcie_clk);
      check({tag, "_rx1_count"}, 64'(rx1_cnt), 64'(n1));
      check({tag, "_rx2_count"}, 64'(rx2_cnt), 64'(n2));
      @(posedge pcie_clk);
      #1;
   endtask

   logic [7:0] hdr_tab [0:11] = '{8'h00, 8'h20, 8'h40, 8'h60, 8'h0A, 8'h4A,
                                  8'h0B, 8'h4B, 8'h04, 8'h44, 8'h30, 8'h74};

   initial begin
      beat_t b;
      int    t;
      rx_if.tvalid  = 1'b0;
      rx_if.tdata   = '0;
      rx_if.tkeep   = '0;
      rx_if.tlast   = 1'b0;
      rx_if.tuser   = '0;
      rx1_if.tready = 1'b1;
      rx2_if.tready = 1'b1;
      n1 = 32'd0;
      n2 = 32'd0;

      repeat (3) @(posedge pcie_clk);
      #1 pcie_rst = 1'b0;
      @(negedge pcie_clk);
      check("reset_rx1_tvalid", 64'(rx1_if.tvalid), 64'd0);
      check("reset_rx2_tvalid", 64'(rx2_if.tvalid), 64'd0);
      check("reset_rx1_count", 64'(rx1_cnt), 64'd0);
      check("reset_rx2_count", 64'(rx2_cnt), 64'd0);
      check("reset_rx_tready", 64'(rx_if.tready), 64'd1);
      @(posedge pcie_clk);
      #1;

      // MRd to sink 1, then CplD and CplLk to sink 2
      send_tlp(8'h00, 2, 0);
      drain();
      check_counts("mrd");
      send_tlp(8'h4A, 3, 0);
      send_tlp(8'h0B, 3, 0);
      drain();
      check_counts("cpl");

      // Back-to-back with no bubbles
      expect_full = 1'b1;
      send_tlp(8'h40, 2, 0);
      send_tlp(8'h4A, 3, 0);
      send_tlp(8'h60, 2, 0);
      expect_full = 1'b0;
      drain();
      check_counts("b2b");

      // Sink 2 stalled for 5 cycles in the middle of a CplD
      rx2_if.tready = 1'b0;
      fork
         send_tlp(8'h4A, 3, 0);
         begin
            t = 0;
            @(negedge pcie_clk);
            while (!rx2_if.tvalid && t < 50) begin
               @(negedge pcie_clk);
               t++;
            end
            for (int i = 0; i < 5; i++) begin
               check("stall_rx_tready", 64'(rx_if.tready), 64'd0);
               @(negedge pcie_clk);
            end
            @(posedge pcie_clk);
            #1 rx2_if.tready = 1'b1;
         end
      join
      rx2_if.tready = 1'b0;
      fork
         send_tlp(8'h40, 2, 0);
         begin
            @(negedge pcie_clk);
            check("mwr_accept_while_sink2_stalled", 64'(rx_if.tready), 64'd1);
            check("sink2_still_holding", 64'(rx2_if.tvalid), 64'd1);
         end
      join
      rx2_if.tready = 1'b1;
      drain();
      check_counts("stall");

      // Reset after the first beat of a 3-beat MWr
      rx1_if.tready = 1'b0;
      b = '{d: {32'h1234_5678, 32'h4000_0002}, k: 8'hFF, l: 1'b0, u: 22'h155};
      send_beat(1'b0, b);
      rx_if.tvalid = 1'b0;
      pcie_rst = 1'b1;
      @(posedge pcie_clk);
      #1 pcie_rst = 1'b0;
      q1.delete();
      q2.delete();
      n1 = 32'd0;
      n2 = 32'd0;
      rx1_if.tready = 1'b1;
      @(negedge pcie_clk);
      check("midrst_rx1_tvalid", 64'(rx1_if.tvalid), 64'd0);
      check("midrst_rx2_tvalid", 64'(rx2_if.tvalid), 64'd0);
      check("midrst_rx1_count", 64'(rx1_cnt), 64'd0);
      check("midrst_rx2_count", 64'(rx2_cnt), 64'd0);
      @(posedge pcie_clk);
      #1;
      send_tlp(8'h4A, 3, 0);
      drain();
      check_counts("after_rst");

      // Counter wrap
      @(negedge pcie_clk);
      force dut.rx1_tlp_count_q = 32'hFFFF_FFFF;
      @(posedge pcie_clk);
      #1 release dut.rx1_tlp_count_q;
      n1 = 32'hFFFF_FFFF;
      @(negedge pcie_clk);
      check("rx1_count_prewrap", 64'(rx1_cnt), 64'hFFFF_FFFF);
      @(posedge pcie_clk);
      #1;
      send_tlp(8'h40, 2, 0);
      drain();
      check_counts("wrap");

      // Randomized traffic, gaps and sink back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         logic [7:0] hdr;
         hdr = (($urandom % 3) == 0) ? 8'($urandom) : hdr_tab[$urandom % 12];
         send_tlp(hdr, int'($urandom_range(5, 1)), 2);
      end
      drain();
      rand_ready    = 1'b0;
      rx1_if.tready = 1'b1;
      rx2_if.tready = 1'b1;
      drain();
      check_counts("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      fails++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
